// File: rtl/aes_sbox_feeder_pkg.sv
// Shared definitions for the masked AES S-box feeder.
//   LfsrPoly   : Galois feedback mask for x^32 + x^22 + x^2 + x + 1
//   state_e    : feeder FSM encoding (StSeed, StRun)
//   blind_nrnd : blinding bits per blind group for a given share count
//   rnd_width  : total fresh random bits consumed per cycle
//   num_lfsr   : number of 32-bit LFSRs needed to cover a bit count
//   rotl32     : 32-bit rotate left, used to derive per-LFSR seeds
package aes_sbox_feeder_pkg;

    // Right-shifting Galois form: exponents 32, 22, 2 and 1 map to bits 31, 21, 1 and 0.
    localparam logic [31:0] LfsrPoly = 32'h8020_0003;

    typedef enum logic [0:0] {
        StSeed,
        StRun
    } state_e;

    function automatic int unsigned blind_nrnd(int unsigned shares);
        return shares * (shares - 1);
    endfunction

    function automatic int unsigned rnd_width(int unsigned shares, int unsigned nrnd);
        return 9 * shares * (shares - 1) + 6 * nrnd + 8 * (shares - 1);
    endfunction

    function automatic int unsigned num_lfsr(int unsigned width);
        return (width + 31) / 32;
    endfunction

    function automatic logic [31:0] rotl32(logic [31:0] v, int unsigned n);
        logic [63:0] d;
        d = {v, v} << (n % 32);
        return d[63:32];
    endfunction

endpackage

// File: rtl/prng_lfsr32.sv
// Single 32-bit Galois LFSR with synchronous load and step enable.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset, clears the state to zero
//   load_i  : load seed_i on this edge (wins over en_i)
//   seed_i  : value to load
//   en_i    : advance one step on this edge
//   state_o : current LFSR state
module prng_lfsr32
    import aes_sbox_feeder_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic [31:0] seed_i,
    input  logic        en_i,
    output logic [31:0] state_o
);

    logic [31:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = seed_i;
        end else if (en_i) begin
            state_d = {1'b0, state_q[31:1]} ^ (state_q[0] ? LfsrPoly : 32'h0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/aes_sbox_feeder.sv
// Masking front end and recombining back end for a pipelined masked AES S-box.
// Accepts unmasked bytes, splits them into SHARES Boolean shares with fresh PRNG
// masks, supplies all per-cycle randomness, tracks accepted bytes through the
// S-box latency and recombines the S-box output shares.
//   ClkxCI, RstxCI           : clock, synchronous active-high reset
//   SeedxDI, SeedValidxSI    : PRNG seed and load strobe (zero seeds are ignored)
//   InxDI, InValidxSI        : plaintext byte and valid
//   InReadyxSO               : high while the PRNG is seeded
//   _XxDO                    : masked shares to the S-box, share i at [8i+7:8i]
//   _Zmul*/_Zinv*/_Binv*xDO  : fresh randomness to the S-box
//   _QxDI                    : S-box output shares
//   QxDO, QValidxSO          : recombined result and valid
//   CountxDO                 : number of results delivered (wraps)
module aes_sbox_feeder
    import aes_sbox_feeder_pkg::*;
#(
    parameter int unsigned SHARES     = 2,
    parameter int unsigned LATENCY    = 4,
    parameter int unsigned BLIND_NRND = blind_nrnd(SHARES)
) (
    input  logic                            ClkxCI,
    input  logic                            RstxCI,
    input  logic [31:0]                     SeedxDI,
    input  logic                            SeedValidxSI,
    input  logic [7:0]                      InxDI,
    input  logic                            InValidxSI,
    output logic                            InReadyxSO,
    output logic [8*SHARES-1:0]             _XxDO,
    output logic [2*SHARES*(SHARES-1)-1:0]  _Zmul1xDO,
    output logic [2*SHARES*(SHARES-1)-1:0]  _Zmul2xDO,
    output logic [2*SHARES*(SHARES-1)-1:0]  _Zmul3xDO,
    output logic [SHARES*(SHARES-1)-1:0]    _Zinv1xDO,
    output logic [SHARES*(SHARES-1)-1:0]    _Zinv2xDO,
    output logic [SHARES*(SHARES-1)-1:0]    _Zinv3xDO,
    output logic [2*BLIND_NRND-1:0]         _Binv1xDO,
    output logic [2*BLIND_NRND-1:0]         _Binv2xDO,
    output logic [2*BLIND_NRND-1:0]         _Binv3xDO,
    input  logic [8*SHARES-1:0]             _QxDI,
    output logic [7:0]                      QxDO,
    output logic                            QValidxSO,
    output logic [15:0]                     CountxDO
);

    localparam int unsigned RndW    = rnd_width(SHARES, BLIND_NRND);
    localparam int unsigned NumLfsr = num_lfsr(RndW);
    localparam int unsigned MaskW   = 8 * (SHARES - 1);
    localparam int unsigned AuxW    = RndW - MaskW;
    localparam int unsigned ZmW     = 2 * SHARES * (SHARES - 1);
    localparam int unsigned ZiW     = SHARES * (SHARES - 1);
    localparam int unsigned BW      = 2 * BLIND_NRND;
    localparam int unsigned ZiOff   = 3 * ZmW;
    localparam int unsigned BOff    = ZiOff + 3 * ZiW;

    state_e                   state_q;
    logic                     ready_q;
    logic [NumLfsr*32-1:0]    bank;
    logic                     seed_load;
    logic                     lfsr_en;
    logic                     accept;
    logic [8*SHARES-1:0]      x_q, x_d;
    logic [AuxW-1:0]          aux_q;
    logic [LATENCY:0]         valid_q;
    logic [15:0]              count_q;
    logic [7:0]               share0;
    logic [7:0]               q_sum;

    assign seed_load = SeedValidxSI && (SeedxDI != 32'h0);
    assign lfsr_en   = (state_q == StRun);
    assign accept    = InValidxSI && ready_q;

    // PRNG bank: bits [MaskW-1:0] are the mask bytes, the rest feed the S-box randomness.
    for (genvar k = 0; k < NumLfsr; k++) begin : g_lfsr
        logic [31:0] seed_k;
        assign seed_k = rotl32(SeedxDI, k) ^ 32'(k);

        prng_lfsr32 u_lfsr (
            .clk_i   (ClkxCI),
            .rst_i   (RstxCI),
            .load_i  (seed_load),
            .seed_i  (seed_k),
            .en_i    (lfsr_en),
            .state_o (bank[32*k +: 32])
        );
    end

    if (NumLfsr * 32 > RndW) begin : g_pad
        logic unused_pad;
        assign unused_pad = ^bank[NumLfsr*32-1:RndW];
    end

    always_ff @(posedge ClkxCI) begin
        if (RstxCI) begin
            state_q <= StSeed;
            ready_q <= 1'b0;
        end else begin
            unique case (state_q)
                StSeed: begin
                    if (seed_load) begin
                        state_q <= StRun;
                        ready_q <= 1'b1;
                    end
                end
                StRun: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= StSeed;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Idle cycles still emit fresh sharings of 0x00 so the S-box never sees static data.
    always_comb begin
        x_d    = '0;
        share0 = accept ? InxDI : 8'h00;
        for (int i = 1; i < SHARES; i++) begin
            x_d[8*i +: 8] = bank[8*(i-1) +: 8];
            share0        = share0 ^ bank[8*(i-1) +: 8];
        end
        x_d[7:0] = share0;
    end

    // Sampling the current PRNG state means a reseed on an accept edge uses the old masks.
    always_ff @(posedge ClkxCI) begin
        if (RstxCI) begin
            x_q     <= '0;
            aux_q   <= '0;
            valid_q <= '0;
            count_q <= '0;
        end else begin
            x_q     <= x_d;
            aux_q   <= bank[RndW-1:MaskW];
            valid_q <= {valid_q[LATENCY-1:0], accept};
            if (valid_q[LATENCY]) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

    always_comb begin
        q_sum = 8'h00;
        for (int i = 0; i < SHARES; i++) begin
            q_sum = q_sum ^ _QxDI[8*i +: 8];
        end
    end

    assign InReadyxSO = ready_q;
    assign _XxDO      = x_q;
    assign _Zmul1xDO  = aux_q[0 +: ZmW];
    assign _Zmul2xDO  = aux_q[ZmW +: ZmW];
    assign _Zmul3xDO  = aux_q[2*ZmW +: ZmW];
    assign _Zinv1xDO  = aux_q[ZiOff +: ZiW];
    assign _Zinv2xDO  = aux_q[ZiOff+ZiW +: ZiW];
    assign _Zinv3xDO  = aux_q[ZiOff+2*ZiW +: ZiW];
    assign _Binv1xDO  = aux_q[BOff +: BW];
    assign _Binv2xDO  = aux_q[BOff+BW +: BW];
    assign _Binv3xDO  = aux_q[BOff+2*BW +: BW];
    assign QValidxSO  = valid_q[LATENCY];
    assign QxDO       = valid_q[LATENCY] ? q_sum : 8'h00;
    assign CountxDO   = count_q;

endmodule

// File: tb/tb_aes_sbox_feeder.sv
module tb_aes_sbox_feeder;

    localparam int L = 4;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] seed;
    logic        seed_v;
    logic [7:0]  in_b;
    logic        in_v;
    logic        in_rdy;
    logic [15:0] x;
    logic [3:0]  zm1, zm2, zm3;
    logic [1:0]  zi1, zi2, zi3;
    logic [3:0]  b1, b2, b3;
    logic [15:0] qsh;
    logic [7:0]  q;
    logic        qv;
    logic [15:0] cnt;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int exp_cnt = 0;

    typedef struct {
        logic [7:0] q;
        int         cyc;
    } exp_t;
    exp_t sb_q[$];

    aes_sbox_feeder dut (
        .ClkxCI       (clk),
        .RstxCI       (rst),
        .SeedxDI      (seed),
        .SeedValidxSI (seed_v),
        .InxDI        (in_b),
        .InValidxSI   (in_v),
        .InReadyxSO   (in_rdy),
        ._XxDO        (x),
        ._Zmul1xDO    (zm1),
        ._Zmul2xDO    (zm2),
        ._Zmul3xDO    (zm3),
        ._Zinv1xDO    (zi1),
        ._Zinv2xDO    (zi2),
        ._Zinv3xDO    (zi3),
        ._Binv1xDO    (b1),
        ._Binv2xDO    (b2),
        ._Binv3xDO    (b3),
        ._QxDI        (qsh),
        .QxDO         (q),
        .QValidxSO    (qv),
        .CountxDO     (cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in masked S-box: L register stages, output re-shared with fresh randomness.
    logic [7:0] p0 [L];
    logic [7:0] p1 [L];
    always @(posedge clk) begin
        logic [7:0] r;
        r = 8'($urandom);
        p0[0] <= SBOX[x[7:0] ^ x[15:8]] ^ r;
        p1[0] <= r;
        for (int k = 1; k < L; k++) begin
            p0[k] <= p0[k-1];
            p1[k] <= p1[k-1];
        end
    end
    assign qsh = {p1[L-1], p0[L-1]};

    // Scoreboard: push on observed handshake, pop when QValidxSO fires.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() != 0 && sb_q[0].cyc < cyc) begin
            e = sb_q.pop_front();
            n_chk++;
            n_fail++;
            $display("FAIL missing_result: no QValidxSO at cycle %0d, required QxDO=%02h", e.cyc, e.q);
        end
        if (qv) begin
            n_chk++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_qvalid: QValidxSO=1 QxDO=%02h at cycle %0d, required QValidxSO=0",
                         q, cyc);
            end else begin
                e = sb_q.pop_front();
                exp_cnt++;
                if (q !== e.q || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL qv_result: QxDO=%02h at cycle %0d, required %02h at cycle %0d",
                             q, cyc, e.q, e.cyc);
                end
            end
        end
        if (in_v && in_rdy && !rst) begin
            e.q   = SBOX[in_b];
            e.cyc = cyc + 1 + L;
            sb_q.push_back(e);
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        sb_q.delete();
        exp_cnt = 0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic do_seed(input logic [31:0] s);
        seed   = s;
        seed_v = 1'b1;
        @(posedge clk); #1;
        seed_v = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        n_chk++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if (in_rdy !== 1'b0 || qv !== 1'b0 || cnt !== 16'h0 || q !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_ctrl: rdy=%b qv=%b cnt=%04h q=%02h, required 0/0/0000/00", in_rdy, qv, cnt, q);
        end
        n_chk++;
        if (x !== 16'h0 || {zm1, zm2, zm3, zi1, zi2, zi3, b1, b2, b3} !== 30'h0) begin
            n_fail++;
            $display("FAIL reset_data: x=%04h rnd=%08h, required 0", x,
                     {zm1, zm2, zm3, zi1, zi2, zi3, b1, b2, b3});
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_seed();
        do_seed(32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_chk++;
            if (in_rdy !== 1'b0) begin
                n_fail++;
                $display("FAIL zero_seed_ready: InReadyxSO=%b, required 0", in_rdy);
            end
            @(posedge clk); #1;
        end
        seed   = 32'hDEADBEEF;
        seed_v = 1'b1;
        @(negedge clk);
        n_chk++;
        if (in_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL pre_seed_ready: InReadyxSO=%b, required 0", in_rdy);
        end
        @(posedge clk); #1;
        seed_v = 1'b0;
        @(negedge clk);
        n_chk++;
        if (in_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL seed_ready: InReadyxSO=%b, required 1", in_rdy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_known();
        logic [7:0] kin [3];
        logic [7:0] kat [3];
        int idx = 0;
        int last = 0;
        kin = '{8'h00, 8'h01, 8'h53};
        kat = '{8'h63, 8'h7C, 8'hED};
        for (int i = 0; i < 3; i++) begin
            in_v = 1'b1;
            in_b = kin[i];
            @(posedge clk); #1;
        end
        in_v = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (qv && idx < 3) begin
                n_chk++;
                if (q !== kat[idx] || (idx > 0 && cyc != last + 1)) begin
                    n_fail++;
                    $display("FAIL kat_%0d: QxDO=%02h at cycle %0d, required %02h at cycle %0d",
                             idx, q, cyc, kat[idx], (idx > 0) ? last + 1 : cyc);
                end
                last = cyc;
                idx++;
            end
        end
        n_chk++;
        if (idx != 3) begin
            n_fail++;
            $display("FAIL kat_count: %0d results seen, required 3", idx);
        end
        @(posedge clk); #1;
        drain();
    endtask

    task automatic test_all256();
        do_reset();
        do_seed(32'hCAFEF00D);
        for (int i = 0; i < 256; i++) begin
            in_v = 1'b1;
            in_b = 8'(i);
            @(posedge clk); #1;
        end
        in_v = 1'b0;
        drain();
        @(negedge clk);
        n_chk++;
        if (cnt !== 16'd256) begin
            n_fail++;
            $display("FAIL count_256: CountxDO=%0d, required 256", cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_masking();
        logic [7:0]  prev;
        logic [29:0] prnd;
        prev = 8'h00;
        prnd = '0;
        do_seed(32'hDEADBEEF);
        in_v = 1'b1;
        in_b = 8'hAA;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (i == 3) in_v = 1'b0;
            @(negedge clk);
            n_chk++;
            if ((x[7:0] ^ x[15:8]) !== 8'hAA) begin
                n_fail++;
                $display("FAIL mask_xor_%0d: shares %02h^%02h=%02h, required aa", i, x[7:0], x[15:8],
                         x[7:0] ^ x[15:8]);
            end
            n_chk++;
            if (x[15:8] === 8'h00 || (i > 0 && x[15:8] === prev)) begin
                n_fail++;
                $display("FAIL mask_fresh_%0d: share1=%02h prev=%02h, required nonzero and changed",
                         i, x[15:8], prev);
            end
            if (i > 0) begin
                n_chk++;
                if ({zm1, zm2, zm3, zi1, zi2, zi3, b1, b2, b3} === prnd) begin
                    n_fail++;
                    $display("FAIL rnd_fresh_%0d: randomness=%08h unchanged, required new value", i, prnd);
                end
            end
            prev = x[15:8];
            prnd = {zm1, zm2, zm3, zi1, zi2, zi3, b1, b2, b3};
        end
        @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ((x[7:0] ^ x[15:8]) !== 8'h00) begin
            n_fail++;
            $display("FAIL idle_shares: shares xor=%02h, required 00", x[7:0] ^ x[15:8]);
        end
        @(posedge clk); #1;
        drain();
    endtask

    task automatic test_reseed();
        for (int i = 0; i < 24; i++) begin
            in_v   = 1'b1;
            in_b   = 8'($urandom);
            seed_v = (i == 6 || i == 15);
            seed   = (i == 6) ? 32'h13579BDF : 32'h2468ACE0;
            @(posedge clk); #1;
            if (i == 6 || i == 15) begin
                n_chk++;
                if (in_rdy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL reseed_ready_%0d: InReadyxSO=%b, required 1", i, in_rdy);
                end
            end
        end
        in_v   = 1'b0;
        seed_v = 1'b0;
        drain();
        @(negedge clk);
        n_chk++;
        if (cnt !== 16'(exp_cnt)) begin
            n_fail++;
            $display("FAIL reseed_count: CountxDO=%0d, required %0d", cnt, exp_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midstream();
        in_v = 1'b1;
        in_b = 8'h53;
        @(posedge clk); #1;
        in_v = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        sb_q.delete();
        exp_cnt = 0;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_chk++;
            if (qv !== 1'b0) begin
                n_fail++;
                $display("FAIL midreset_qv_%0d: QValidxSO=%b, required 0", i, qv);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_chk++;
        if (cnt !== 16'h0 || in_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_state: CountxDO=%0d rdy=%b, required 0/0", cnt, in_rdy);
        end
        @(posedge clk); #1;
        do_seed(32'h0BADF00D);
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic test_count_wrap();
        do_reset();
        do_seed(32'h5EED5EED);
        for (int i = 0; i < 65537; i++) begin
            in_v = 1'b1;
            in_b = 8'($urandom);
            @(posedge clk); #1;
        end
        in_v = 1'b0;
        drain();
        @(negedge clk);
        n_chk++;
        if (cnt !== 16'h0001) begin
            n_fail++;
            $display("FAIL count_wrap: CountxDO=%04h, required 0001", cnt);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        seed   = 32'h0;
        seed_v = 1'b0;
        in_b   = 8'h00;
        in_v   = 1'b0;
        test_reset();
        test_seed();
        test_known();
        test_all256();
        test_masking();
        test_reseed();
        test_reset_midstream();
        test_count_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
